// File: rtl/mem_loader_pkg.sv
// Shared types and default widths for the memory-image loader, its RAM and
// the memory-override bench interface.
package mem_loader_pkg;

    localparam int DEFAULT_REG_WIDTH  = 8;
    localparam int DEFAULT_ADDR_WIDTH = 16;

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        VERIFY,
        DRAIN,
        DONE
    } loader_state_e;

endpackage

// File: rtl/mem_loader_if.sv
// Byte stream and RAM bus seen by the loader: master is the loader side,
// slave is the stream source plus RAM.
interface mem_loader_if
    import mem_loader_pkg::*;
#(
    parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  s_valid;
    logic [REG_WIDTH-1:0]  s_data;
    logic                  s_ready;
    logic                  mem_we;
    logic                  mem_re;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic [REG_WIDTH-1:0]  mem_rdata;

    modport master (
        input  s_valid, s_data, mem_rdata,
        output s_ready, mem_we, mem_re, mem_addr, mem_wdata
    );

    modport slave (
        output s_valid, s_data, mem_rdata,
        input  s_ready, mem_we, mem_re, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_loader_byte_sum_acc.sv
// Modulo-2^REG_WIDTH additive byte accumulator with synchronous clear.
module byte_sum_acc
    import mem_loader_pkg::*;
#(
    parameter int REG_WIDTH = DEFAULT_REG_WIDTH
) (
    input  logic                 clk,
    input  logic                 clear,
    input  logic                 en,
    input  logic [REG_WIDTH-1:0] data,
    output logic [REG_WIDTH-1:0] sum
);

    always_ff @(posedge clk) begin
        if (clear) begin
            sum <= '0;
        end else if (en) begin
            sum <= sum + data;
        end
    end

endmodule

// File: rtl/mem_loader.sv
// Streams a byte image into RAM, reads it back, compares additive checksums
// and releases cpu_hold only after a clean load.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
    mem_loader_if.master          bus,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [REG_WIDTH-1:0]  checksum,
    output logic                  cpu_hold
);

    loader_state_e state, state_nxt;

    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   wcount;
    logic [ADDR_WIDTH:0]   rcount;
    logic [REG_WIDTH-1:0]  rb_sum;
    logic                  start_acc;
    logic                  xfer;
    logic                  last_wr;
    logic                  last_rd;
    logic                  rd_vld_p1;
    logic                  acc_clear;

    assign start_acc = (state == IDLE) && start;
    assign xfer      = (state == WRITE) && bus.s_valid;
    assign last_wr   = (wcount + (ADDR_WIDTH+1)'(1)) == len_q;
    assign last_rd   = (rcount + (ADDR_WIDTH+1)'(1)) == len_q;
    assign acc_clear = !reset_n || start_acc;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (length == '0) ? DONE : WRITE;
            WRITE:   if (xfer && last_wr) state_nxt = VERIFY;
            VERIFY:  if (last_rd) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Strobes are combinational so a write lands in the same cycle as its handshake.
    always_comb begin
        bus.s_ready   = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_re    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        busy          = (state != IDLE);
        done          = (state == DONE);
        case (state)
            WRITE: begin
                bus.s_ready = 1'b1;
                if (bus.s_valid) begin
                    bus.mem_we    = 1'b1;
                    bus.mem_addr  = base_q + wcount[ADDR_WIDTH-1:0];
                    bus.mem_wdata = bus.s_data;
                end
            end
            VERIFY: begin
                bus.mem_re   = 1'b1;
                bus.mem_addr = base_q + rcount[ADDR_WIDTH-1:0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (start_acc) begin
            base_q <= base_addr;
            len_q  <= length;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n || start_acc) begin
            wcount <= '0;
            rcount <= '0;
        end else begin
            if (xfer) wcount <= wcount + (ADDR_WIDTH+1)'(1);
            if (state == VERIFY) rcount <= rcount + (ADDR_WIDTH+1)'(1);
        end
    end

    // Read issue -> read data stage: RAM answers one cycle after mem_re.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_vld_p1 <= 1'b0;
        end else begin
            rd_vld_p1 <= (state == VERIFY);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else if (start_acc) begin
            error    <= 1'b0;
            cpu_hold <= 1'b1;
        end else if (state == DONE) begin
            if (rb_sum != checksum) begin
                error    <= 1'b1;
                cpu_hold <= 1'b1;
            end else begin
                cpu_hold <= 1'b0;
            end
        end
    end

    byte_sum_acc #(.REG_WIDTH(REG_WIDTH)) u_wr_sum (
        .clk   (clk),
        .clear (acc_clear),
        .en    (xfer),
        .data  (bus.s_data),
        .sum   (checksum)
    );

    byte_sum_acc #(.REG_WIDTH(REG_WIDTH)) u_rb_sum (
        .clk   (clk),
        .clear (acc_clear),
        .en    (rd_vld_p1),
        .data  (bus.mem_rdata),
        .sum   (rb_sum)
    );

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: directed loads push expected writes, reads
// and completion results; a negedge monitor pops and compares them.
module tb_mem_loader;

    localparam int RW = 8;
    localparam int AW = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;
    logic          error;
    logic [RW-1:0] checksum;
    logic          cpu_hold;

    always #5 clk = ~clk;

    mem_loader_if #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) bus ();

    mem_loader #(.REG_WIDTH(RW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum),
        .cpu_hold  (cpu_hold)
    );

    // RAM model; corrupt flips bit 0 of the byte at 0x0201 on readback
    logic [7:0] ram [0:65535];
    logic       corrupt = 1'b0;

    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re)
            bus.mem_rdata <= ram[bus.mem_addr] ^
                             ((corrupt && bus.mem_addr == 16'h0201) ? 8'h01 : 8'h00);
    end

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  sum;
        logic        err;
        logic        hold;
    } done_t;

    wr_t         exp_wr[$];
    logic [15:0] exp_rd[$];
    done_t       exp_done[$];
    logic [7:0]  img[$];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   t0 = 0;
    logic post_pend = 1'b0;
    logic post_err;
    logic post_hold;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (post_pend) begin
            check("post_error", {31'b0, error}, {31'b0, post_err});
            check("post_cpu_hold", {31'b0, cpu_hold}, {31'b0, post_hold});
            check("post_busy", {31'b0, busy}, 32'd0);
            post_pend = 1'b0;
        end
        check("we_re_exclusive", {31'b0, bus.mem_we & bus.mem_re}, 32'd0);
        if (bus.mem_we) begin
            if (exp_wr.size() == 0) begin
                check("wr_unexpected", {31'b0, bus.mem_we}, 32'd0);
            end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("wr_addr", {16'b0, bus.mem_addr}, {16'b0, w.addr});
                check("wr_data", {24'b0, bus.mem_wdata}, {24'b0, w.data});
            end
        end
        if (bus.mem_re) begin
            if (exp_rd.size() == 0) begin
                check("rd_unexpected", {31'b0, bus.mem_re}, 32'd0);
            end else begin
                logic [15:0] a;
                a = exp_rd.pop_front();
                check("rd_addr", {16'b0, bus.mem_addr}, {16'b0, a});
            end
        end
        if (done) begin
            if (exp_done.size() == 0) begin
                check("done_unexpected", {31'b0, done}, 32'd0);
            end else begin
                done_t d;
                d = exp_done.pop_front();
                check("done_cycle", 32'(cyc - t0 + 1), d.cyc);
                check("done_checksum", {24'b0, checksum}, {24'b0, d.sum});
                post_err  = d.err;
                post_hold = d.hold;
                post_pend = 1'b1;
            end
        end
    end

    task automatic expect_load(input logic [15:0] b, input int dcyc, input logic [7:0] sum,
                               input logic err, input logic hold);
        for (int i = 0; i < img.size(); i++) exp_wr.push_back({b + 16'(i), img[i]});
        for (int i = 0; i < img.size(); i++) exp_rd.push_back(b + 16'(i));
        exp_done.push_back({32'(dcyc), sum, err, hold});
    endtask

    task automatic do_start(input logic [15:0] b, input logic [16:0] n);
        base_addr = b;
        length    = n;
        start     = 1'b1;
        @(posedge clk);
        #1;
        t0    = cyc;
        start = 1'b0;
    endtask

    task automatic send_img();
        for (int i = 0; i < img.size(); i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = img[i];
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            if (!busy && !post_pend) break;
            @(posedge clk);
            #1;
        end
        check({tag, "_finished"}, {31'b0, (k < 400)}, 32'd1);
        check({tag, "_wr_drained"}, 32'(exp_wr.size()), 32'd0);
        check({tag, "_rd_drained"}, 32'(exp_rd.size()), 32'd0);
        check({tag, "_done_drained"}, 32'(exp_done.size()), 32'd0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        length      = '0;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        check("rst_mem_we", {31'b0, bus.mem_we}, 32'd0);
        check("rst_mem_re", {31'b0, bus.mem_re}, 32'd0);
        check("rst_mem_addr", {16'b0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {24'b0, bus.mem_wdata}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        check("rst_checksum", {24'b0, checksum}, 32'd0);
        check("rst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic load
        img = '{8'hA9, 8'h01, 8'h8D, 8'h00};
        expect_load(16'h0200, 10, 8'h37, 1'b0, 1'b0);
        do_start(16'h0200, 17'd4);
        check("basic_busy", {31'b0, busy}, 32'd1);
        check("basic_hold_during", {31'b0, cpu_hold}, 32'd1);
        send_img();
        wait_idle("basic");

        // Address wrap
        img = '{8'h11, 8'h22, 8'h33, 8'h44};
        expect_load(16'hFFFE, 10, 8'hAA, 1'b0, 1'b0);
        do_start(16'hFFFE, 17'd4);
        send_img();
        wait_idle("wrap");

        // Stalls with a start pulse mid-WRITE
        img = '{8'h5A, 8'hC3, 8'h0F};
        expect_load(16'h0300, 12, 8'h2C, 1'b0, 1'b0);
        do_start(16'h0300, 17'd3);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                bus.s_valid = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    if (i == 1 && s == 0) begin
                        start     = 1'b1;
                        base_addr = 16'h1234;
                        length    = 17'd9;
                    end
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
            bus.s_valid = 1'b1;
            bus.s_data  = img[i];
            @(posedge clk);
            #1;
        end
        bus.s_valid = 1'b0;
        wait_idle("stall");

        // Readback corruption
        corrupt = 1'b1;
        img = '{8'hA9, 8'h01, 8'h8D, 8'h00};
        expect_load(16'h0200, 10, 8'h37, 1'b1, 1'b1);
        do_start(16'h0200, 17'd4);
        send_img();
        wait_idle("corrupt");
        corrupt = 1'b0;

        // Zero length
        img.delete();
        expect_load(16'h0500, 1, 8'h00, 1'b0, 1'b0);
        do_start(16'h0500, 17'd0);
        check("len0_error_cleared", {31'b0, error}, 32'd0);
        check("len0_hold_set", {31'b0, cpu_hold}, 32'd1);
        wait_idle("len0");

        // Reset mid-WRITE after two of four bytes
        exp_wr.push_back({16'h0400, 8'h10});
        exp_wr.push_back({16'h0401, 8'h20});
        do_start(16'h0400, 17'd4);
        img = '{8'h10, 8'h20};
        send_img();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_s_ready", {31'b0, bus.s_ready}, 32'd0);
        check("midrst_cpu_hold", {31'b0, cpu_hold}, 32'd1);
        check("midrst_checksum", {24'b0, checksum}, 32'd0);
        check("midrst_wr_seen", 32'(exp_wr.size()), 32'd0);
        @(posedge clk);
        #1;

        // Fresh load after reset
        img = '{8'h10, 8'h20, 8'h30, 8'h40};
        expect_load(16'h0400, 10, 8'hA0, 1'b0, 1'b0);
        do_start(16'h0400, 17'd4);
        send_img();
        wait_idle("fresh");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
